// File: rtl/vga_raster_timing_if.sv
// Raster timing bundle between the timing generator
// and the pixel-shading stage.
interface vga_raster_timing_if;
  logic        ce;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [10:0] frame_count;

  modport master (
    input  ce,
    output hpos,
    output vpos,
    output display_on,
    output hsync,
    output vsync,
    output line_start,
    output frame_start,
    output frame_count
  );

  modport slave (
    output ce,
    input  hpos,
    input  vpos,
    input  display_on,
    input  hsync,
    input  vsync,
    input  line_start,
    input  frame_start,
    input  frame_count
  );
endinterface

// File: rtl/vga_raster_timing.sv
// VGA raster timing generator: counters, blanking, syncs,
// strobes and frame counter, all co-registered.
module vga_raster_timing #(
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  vga_raster_timing_if.master vga
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  localparam int HS_BEG = H_DISPLAY + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_DISPLAY + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;

  // Pin level when no pulse is being driven.
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  logic [9:0]  hpos_q;
  logic [9:0]  vpos_q;
  logic        disp_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        ls_q;
  logic        fs_q;
  logic [10:0] fc_q;

  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic        h_wrap;
  logic        disp_nxt;
  logic        hs_act;
  logic        vs_act;
  logic        at_h0;
  logic        fc_inc;

  // Next raster position and the decodes that describe it,
  // so the registered outputs line up with the counters.
  always_comb begin
    h_wrap   = (hpos_q == H_LAST);
    h_nxt    = hpos_q + 10'd1;
    v_nxt    = vpos_q;
    if (h_wrap) begin
      h_nxt = '0;
      v_nxt = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
    end
    disp_nxt = (int'(h_nxt) < H_DISPLAY) &&
               (int'(v_nxt) < V_DISPLAY);
    hs_act   = (int'(h_nxt) >= HS_BEG) &&
               (int'(h_nxt) < HS_END);
    vs_act   = (int'(v_nxt) >= VS_BEG) &&
               (int'(v_nxt) < VS_END);
    at_h0    = (h_nxt == '0);
    fc_inc   = at_h0 && (int'(v_nxt) == VS_BEG);
  end

  // State register; a stalled cycle holds everything and
  // only drops the strobes, so pending events are deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= H_LAST;
      vpos_q  <= V_LAST;
      disp_q  <= 1'b0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
    end else if (vga.ce) begin
      hpos_q  <= h_nxt;
      vpos_q  <= v_nxt;
      disp_q  <= disp_nxt;
      hsync_q <= hs_act ? ~SYNC_IDLE : SYNC_IDLE;
      vsync_q <= vs_act ? ~SYNC_IDLE : SYNC_IDLE;
      ls_q    <= at_h0;
      fs_q    <= at_h0 && (v_nxt == '0);
      if (fc_inc) begin
        fc_q <= fc_q + 11'd1;
      end
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end
  end

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.display_on  = disp_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_raster_timing.sv
// Bench for vga_raster_timing: a full-size 640x480 instance
// and a tiny 5x5 active-high-sync instance for frame tests.
module tb_vga_raster_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  vga_raster_timing_if ifa ();
  vga_raster_timing_if ifb ();

  vga_raster_timing u_a (
    .clk   (clk),
    .rst_n (rst_a),
    .vga   (ifa)
  );

  vga_raster_timing #(
    .H_DISPLAY       (2),
    .H_FRONT         (1),
    .H_SYNC          (1),
    .H_BACK          (1),
    .V_DISPLAY       (2),
    .V_FRONT         (1),
    .V_SYNC          (1),
    .V_BACK          (1),
    .SYNC_ACTIVE_LOW (0)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_b),
    .vga   (ifb)
  );

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        d;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [10:0] fc;
  } exp_t;

  // Hand-entered geometry: index 0 = 640x480, 1 = tiny.
  int HT  [2] = '{800, 5};
  int VT  [2] = '{525, 5};
  int HD  [2] = '{640, 2};
  int VD  [2] = '{480, 2};
  int HS0 [2] = '{656, 3};
  int HS1 [2] = '{752, 4};
  int VS0 [2] = '{490, 3};
  int VS1 [2] = '{492, 4};
  bit LOW [2] = '{1'b1, 1'b0};

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];

  int mh    [2];
  int mv    [2];
  int mfc   [2];
  bit mstep [2];

  task automatic check(string n, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, req);
    end
  endtask

  task automatic sb_cmp(string n, exp_t a, exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display(
        "FAIL %s @%0t: got h=%0d v=%0d d=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d d=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
        n, $time, a.h, a.v, a.d, a.hs, a.vs, a.ls, a.fs, a.fc,
        e.h, e.v, e.d, e.hs, e.vs, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic model_step(int d, logic c, logic r);
    if (!r) begin
      mh[d]    = HT[d] - 1;
      mv[d]    = VT[d] - 1;
      mfc[d]   = 0;
      mstep[d] = 1'b0;
    end else if (c) begin
      mh[d]++;
      if (mh[d] == HT[d]) begin
        mh[d] = 0;
        mv[d]++;
        if (mv[d] == VT[d]) mv[d] = 0;
      end
      if (mh[d] == 0 && mv[d] == VS0[d])
        mfc[d] = (mfc[d] + 1) % 2048;
      mstep[d] = 1'b1;
    end else begin
      mstep[d] = 1'b0;
    end
  endtask

  function automatic exp_t expect_of(int d);
    exp_t e;
    bit   ha;
    bit   va;
    e.h  = 10'(mh[d]);
    e.v  = 10'(mv[d]);
    e.d  = (mh[d] < HD[d]) && (mv[d] < VD[d]);
    ha   = (mh[d] >= HS0[d]) && (mh[d] < HS1[d]);
    va   = (mv[d] >= VS0[d]) && (mv[d] < VS1[d]);
    e.hs = LOW[d] ? !ha : ha;
    e.vs = LOW[d] ? !va : va;
    e.ls = mstep[d] && (mh[d] == 0);
    e.fs = e.ls && (mv[d] == 0);
    e.fc = 11'(mfc[d]);
    return e;
  endfunction

  function automatic exp_t sample_a();
    exp_t s;
    s = '{ifa.hpos, ifa.vpos, ifa.display_on, ifa.hsync,
          ifa.vsync, ifa.line_start, ifa.frame_start,
          ifa.frame_count};
    return s;
  endfunction

  function automatic exp_t sample_b();
    exp_t s;
    s = '{ifb.hpos, ifb.vpos, ifb.display_on, ifb.hsync,
          ifb.vsync, ifb.line_start, ifb.frame_start,
          ifb.frame_count};
    return s;
  endfunction

  // One clock for DUT d with clock-enable c; expected
  // response goes to that DUT's scoreboard queue.
  task automatic cyc(int d, logic c);
    if (d == 0) ifa.ce = c;
    else        ifb.ce = c;
    @(posedge clk);
    model_step(d, c, (d == 0) ? rst_a : rst_b);
    if (d == 0) qa.push_back(expect_of(0));
    else        qb.push_back(expect_of(1));
    #1;
  endtask

  // Monitor: compares each issued cycle's response.
  always @(negedge clk) begin
    if (qa.size() > 0) sb_cmp("raster_a", sample_a(), qa.pop_front());
    if (qb.size() > 0) sb_cmp("raster_b", sample_b(), qb.pop_front());
  end

  initial begin
    int dcnt;
    int hcnt;
    int hfirst;
    int lscnt;
    int last_fs;
    int vs_cnt;
    int vs_h;
    int vs_v;

    ifa.ce = 1'b1;
    ifb.ce = 1'b1;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    model_step(0, 1'b1, 1'b0);
    model_step(1, 1'b1, 1'b0);

    // Full-size instance: reset and first pixel.
    repeat (3) cyc(0, 1'b1);
    check("a_rst_hpos", ifa.hpos, 799);
    check("a_rst_vpos", ifa.vpos, 524);
    check("a_rst_disp", ifa.display_on, 0);
    check("a_rst_hsync", ifa.hsync, 1);
    check("a_rst_vsync", ifa.vsync, 1);

    rst_a = 1'b1;
    cyc(0, 1'b1);
    check("a_first_hpos", ifa.hpos, 0);
    check("a_first_vpos", ifa.vpos, 0);
    check("a_first_disp", ifa.display_on, 1);
    check("a_first_fs", ifa.frame_start, 1);
    check("a_first_ls", ifa.line_start, 1);

    // Clock-enable stall at hpos=100.
    repeat (100) cyc(0, 1'b1);
    repeat (10) begin
      cyc(0, 1'b0);
      check("a_ce_hold_hpos", ifa.hpos, 100);
      check("a_ce_hold_ls", ifa.line_start, 0);
    end
    cyc(0, 1'b1);
    check("a_ce_resume_hpos", ifa.hpos, 101);

    // One complete visible line (vpos=1).
    repeat (699) cyc(0, 1'b1);
    check("a_line1_vpos", ifa.vpos, 1);
    dcnt   = 0;
    hcnt   = 0;
    hfirst = -1;
    lscnt  = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) cyc(0, 1'b1);
      if (ifa.display_on) dcnt++;
      if (ifa.line_start) lscnt++;
      if (!ifa.hsync) begin
        hcnt++;
        if (hfirst < 0) hfirst = int'(ifa.hpos);
      end
    end
    check("a_disp_cycles", dcnt, 640);
    check("a_hsync_cycles", hcnt, 96);
    check("a_hsync_start", hfirst, 656);
    check("a_ls_in_line", lscnt, 1);
    cyc(0, 1'b1);
    check("a_ls_period", ifa.line_start, 1);

    // Asynchronous reset mid-line at hpos=300.
    repeat (300) cyc(0, 1'b1);
    check("a_pre_rst_hpos", ifa.hpos, 300);
    #2;
    qa.delete();
    rst_a = 1'b0;
    model_step(0, 1'b1, 1'b0);
    #1;
    check("a_async_hpos", ifa.hpos, 799);
    check("a_async_vpos", ifa.vpos, 524);
    check("a_async_disp", ifa.display_on, 0);
    check("a_async_hsync", ifa.hsync, 1);
    check("a_async_vsync", ifa.vsync, 1);
    check("a_async_fc", ifa.frame_count, 0);
    repeat (2) cyc(0, 1'b1);
    rst_a = 1'b1;
    cyc(0, 1'b1);
    check("a_rerelease_fs", ifa.frame_start, 1);

    // Tiny instance, active-high syncs.
    repeat (2) cyc(1, 1'b1);
    check("b_rst_hpos", ifb.hpos, 4);
    check("b_rst_vpos", ifb.vpos, 4);
    check("b_rst_hsync", ifb.hsync, 0);
    check("b_rst_vsync", ifb.vsync, 0);
    check("b_rst_fc", ifb.frame_count, 0);

    rst_b = 1'b1;
    cyc(1, 1'b1);
    check("b_first_fs", ifb.frame_start, 1);
    check("b_first_disp", ifb.display_on, 1);

    // Three frames: strobe period, vsync window, counter.
    last_fs = 0;
    vs_cnt  = 0;
    vs_h    = -1;
    vs_v    = -1;
    for (int i = 1; i <= 75; i++) begin
      cyc(1, 1'b1);
      if (ifb.frame_start) begin
        check("b_fs_period", i - last_fs, 25);
        last_fs = i;
      end
      if (ifb.vsync) begin
        vs_cnt++;
        if (vs_h < 0) begin
          vs_h = int'(ifb.hpos);
          vs_v = int'(ifb.vpos);
        end
      end
    end
    check("b_fs_last", last_fs, 75);
    check("b_vsync_cycles", vs_cnt, 15);
    check("b_vsync_start_h", vs_h, 0);
    check("b_vsync_start_v", vs_v, 3);
    check("b_fc_after3", ifb.frame_count, 3);

    // Run up to 2047 frames, then one more to wrap.
    repeat (2044 * 25) cyc(1, 1'b1);
    check("b_fc_2047", ifb.frame_count, 2047);
    repeat (25) cyc(1, 1'b1);
    check("b_fc_wrap", ifb.frame_count, 0);

    // Stall where the next step would bump frame_count.
    repeat (14) cyc(1, 1'b1);
    check("b_pre_inc_hpos", ifb.hpos, 4);
    check("b_pre_inc_vpos", ifb.vpos, 2);
    repeat (3) cyc(1, 1'b0);
    check("b_inc_held_fc", ifb.frame_count, 0);
    cyc(1, 1'b1);
    check("b_inc_deferred_fc", ifb.frame_count, 1);
    check("b_inc_deferred_v", ifb.vpos, 3);

    // Stall on the last raster position.
    repeat (9) cyc(1, 1'b1);
    check("b_last_hpos", ifb.hpos, 4);
    check("b_last_vpos", ifb.vpos, 4);
    repeat (3) begin
      cyc(1, 1'b0);
      check("b_wrap_hold_h", ifb.hpos, 4);
      check("b_wrap_hold_fs", ifb.frame_start, 0);
    end
    cyc(1, 1'b1);
    check("b_wrap_hpos", ifb.hpos, 0);
    check("b_wrap_vpos", ifb.vpos, 0);
    check("b_wrap_fs", ifb.frame_start, 1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
